letter2ps2_tx: RTL

- Converts a 5-bit letter index (1=A … 26=Z) back into its PS/2 Set-2 scan code.
- Serialises the code as a device-side PS/2 keystroke: make code, then break sequence F0 + code.
- Used to emit Enigma-encrypted letters as an emulated keyboard stream, or as a loopback stimulus source for the keyboard-receive path.
- Sits between the rotor/plugboard output and the PMOD PS/2 output pins.

---
 rtl/letter2ps2_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/letter2ps2_tx.sv
// letter2ps2_tx: maps a letter index to its PS/2 Set-2 scan code and sends it as a device-side make/break keystroke.
module letter2ps2_tx #(
  parameter int HALF_PERIOD = 4000,
  parameter int GAP_CYCLES = 8000,
  parameter bit SEND_BREAK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] letter_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       ps2_clk_out,
  output logic       ps2_data_out,
  output logic       busy,
  output logic       err_invalid
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  localparam int HW = HALF_PERIOD > 2 ? $clog2(HALF_PERIOD) : 1;
  localparam int GW = GAP_CYCLES > 2 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [1:0] B_LAST = SEND_BREAK ? 2'd2 : 2'd0;
  state_t state;
  logic [HW-1:0] hcnt;
  logic [GW-1:0] gcnt;
  logic low;
  logic [3:0] bit_cnt;
  logic [1:0] byte_idx;
  logic [7:0] code;
  logic [7:0] lut_code;
  logic [10:0] shreg;
  logic letter_ok;
  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction
  always_comb begin
    case (letter_in)
      5'd1: lut_code = 8'h1C;
      5'd2: lut_code = 8'h32;
      5'd3: lut_code = 8'h21;
      5'd4: lut_code = 8'h23;
      5'd5: lut_code = 8'h24;
      5'd6: lut_code = 8'h2B;
      5'd7: lut_code = 8'h34;
      5'd8: lut_code = 8'h33;
      5'd9: lut_code = 8'h43;
      5'd10: lut_code = 8'h3B;
      5'd11: lut_code = 8'h42;
      5'd12: lut_code = 8'h4B;
      5'd13: lut_code = 8'h3A;
      5'd14: lut_code = 8'h31;
      5'd15: lut_code = 8'h44;
      5'd16: lut_code = 8'h4D;
      5'd17: lut_code = 8'h15;
      5'd18: lut_code = 8'h2D;
      5'd19: lut_code = 8'h1B;
      5'd20: lut_code = 8'h2C;
      5'd21: lut_code = 8'h3C;
      5'd22: lut_code = 8'h2A;
      5'd23: lut_code = 8'h1D;
      5'd24: lut_code = 8'h22;
      5'd25: lut_code = 8'h35;
      5'd26: lut_code = 8'h1A;
      default: lut_code = 8'h00;
    endcase
  end
  // no valid letter maps to 00, so a zero lookup doubles as the range check
  assign letter_ok = lut_code != 8'h00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready_out <= 1'b1;
      ps2_clk_out <= 1'b1;
      ps2_data_out <= 1'b1;
      busy <= 1'b0;
      err_invalid <= 1'b0;
      hcnt <= '0;
      gcnt <= '0;
      low <= 1'b0;
      bit_cnt <= 4'd0;
      byte_idx <= 2'd0;
      code <= 8'h00;
      shreg <= '1;
    end else begin
      err_invalid <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in && letter_ok) begin
            code <= lut_code;
            shreg <= frame(lut_code);
            ps2_data_out <= 1'b0;
            state <= SEND;
            ready_out <= 1'b0;
            busy <= 1'b1;
            byte_idx <= 2'd0;
            bit_cnt <= 4'd0;
            hcnt <= '0;
            low <= 1'b0;
          end else if (valid_in) begin
            err_invalid <= 1'b1;
          end
        end
        SEND: begin
          if (hcnt == H_LAST) begin
            hcnt <= '0;
            low <= ~low;
            ps2_clk_out <= low;
            // a bit ends after its low half; data moves only at the start of the next bit
            if (low && bit_cnt == 4'd10) begin
              state <= GAP;
              bit_cnt <= 4'd0;
              gcnt <= '0;
            end else if (low) begin
              bit_cnt <= bit_cnt + 4'd1;
              ps2_data_out <= shreg[1];
              shreg <= shreg >> 1;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        GAP: begin
          if (gcnt == G_LAST) begin
            gcnt <= '0;
            if (byte_idx == B_LAST) begin
              state <= IDLE;
              ready_out <= 1'b1;
              busy <= 1'b0;
              byte_idx <= 2'd0;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              shreg <= frame(byte_idx == 2'd0 ? 8'hF0 : code);
              ps2_data_out <= 1'b0;
              state <= SEND;
            end
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
